// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory.
// Provides: access-size encodings, FSM state type, byte-enable generation
// and load extraction/extension helpers (32-bit word semantics).
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Byte enable for an aligned access of the given size starting at lane.
    function automatic logic [LANES-1:0] lane_be(input logic [1:0] size,
                                                 input logic [1:0] lane);
        logic [LANES-1:0] be;
        be = '0;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

    // Pick the addressed byte/half, move it to bit 0 and sign/zero extend.
    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lane,
                                                      input logic              uns);
        logic [7:0]        byte_v;
        logic [15:0]       half_v;
        logic [WORD_W-1:0] res;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    res = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    res = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with a per-byte write enable and async read port.
// Ports: clk; wr_be/wr_idx/wr_data write port (commits on rising edge);
//        rd_idx -> rd_data combinational read.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic [NB-1:0]     wr_be,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; lanes with a clear enable keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_bytewise.sv
// Byte-addressable data memory with LB/LH/LW(U) and SB/SH/SW support.
// Request/response handshake, one-cycle registered read latency, error flag
// for misaligned, out-of-range or reserved-size accesses. After reset the
// whole array is scrubbed to zero (DEPTH cycles) before requests are taken.
// Ports: clk, rst (sync, active high);
//        req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err; busy_init (scrub running).
module data_mem_bytewise
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy_init
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NB    = DATA_W / 8;

    // Load/store lane semantics are defined for 32-bit words only.
    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_mem_bytewise: DATA_W must be 32");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  cnt;

    logic [1:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic              acc_err;
    logic              accept;
    logic [DATA_W-1:0] store_lanes;

    logic [NB-1:0]     wr_be;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    assign lane = req_addr[1:0];
    assign idx  = req_addr[IDX_W+1:2];

    // Any address bit above the array range makes the access out of range.
    assign acc_err = (req_size == SZ_RSV)
                   || ((req_size == SZ_H) && req_addr[0])
                   || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
                   || (|(req_addr >> (IDX_W + 2)));

    assign req_ready = !rst && (state == RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign busy_init = (state == SCRUB);

    // Replicate store data across lanes; the byte enable picks the target.
    always_comb begin
        store_lanes = req_wdata;
        case (req_size)
            SZ_B:    store_lanes = {4{req_wdata[7:0]}};
            SZ_H:    store_lanes = {2{req_wdata[15:0]}};
            default: store_lanes = req_wdata;
        endcase
    end

    // Write port: scrub zeros during SCRUB, otherwise error-free stores.
    always_comb begin
        wr_be   = '0;
        wr_idx  = cnt;
        wr_data = '0;
        if (!rst) begin
            if (state == SCRUB) begin
                wr_be = '1;
            end else if (accept && req_we && !acc_err) begin
                wr_be   = lane_be(req_size, lane);
                wr_idx  = idx;
                wr_data = store_lanes;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_array (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // State register and scrub counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCRUB;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == SCRUB) begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    // Next state: leave SCRUB after the last index has been written.
    always_comb begin
        state_nxt = state;
        case (state)
            SCRUB:   if (cnt == IDX_W'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = SCRUB;
        endcase
    end

    // Response register: load on accept, hold under backpressure, else drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || req_we) ? '0
                       : load_extend(rd_data, req_size, lane, req_unsigned);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_bytewise.sv
module tb_data_mem_bytewise;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy_init;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_bytewise #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy_init    (busy_init)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: flat byte array ----------------
    logic [7:0]  bmem [NBYTES];
    bit          live = 1'b0;
    int          scrub_left = 0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;

    function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(NBYTES));
    endfunction

    always @(posedge clk) begin
        int          nb;
        logic [31:0] v;
        if (rst) begin
            live       = 1'b1;
            scrub_left = DEPTH;
            exp_valid  = 1'b0;
            for (int i = 0; i < int'(NBYTES); i++) bmem[i] = 8'h00;
        end else if (live) begin
            if (scrub_left > 0) begin
                scrub_left--;
            end else if (req_valid && (!exp_valid || rsp_ready)) begin
                nb        = 1 << req_size;
                exp_valid = 1'b1;
                exp_err   = is_err(req_size, req_addr);
                exp_rdata = 32'h0;
                if (!exp_err) begin
                    if (req_we) begin
                        for (int i = 0; i < nb; i++)
                            bmem[8'(req_addr + 32'(i))] = req_wdata[8*i +: 8];
                    end else begin
                        v = 32'h0;
                        for (int i = 0; i < nb; i++)
                            v[8*i +: 8] = bmem[8'(req_addr + 32'(i))];
                        if (!req_unsigned && nb < 4 && v[8*nb-1])
                            v = v | ~((32'd1 << (8*nb)) - 32'd1);
                        exp_rdata = v;
                    end
                end
            end else if (rsp_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            check("busy_init", 32'(busy_init), 32'(scrub_left > 0));
            check("req_ready", 32'(req_ready),
                  32'(!rst && scrub_left == 0 && (!exp_valid || rsp_ready)));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // ---------------- directed stimulus (tasks start/end at posedge+1) ----------------
    task automatic start_req(input bit we, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic wait_accept(input string name);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: req_ready stayed 0 expected 1", name);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [31:0] er, input bit ee);
        @(negedge clk);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_rdata"}, rsp_rdata, er);
        check({name, "_err"}, 32'(rsp_err), 32'(ee));
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string name, input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input bit ee);
        start_req(we, sz, uns, a, d);
        wait_accept(name);
        get_rsp(name, er, ee);
    endtask

    // Counts busy_init cycles; returns at the negedge where it has dropped.
    task automatic count_scrub(input string name);
        int cnt = 0;
        int k = 0;
        @(negedge clk);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        while (busy_init && k < 300) begin
            check({name, "_req_ready"}, 32'(req_ready), 32'd0);
            cnt++;
            k++;
            @(negedge clk);
        end
        check({name, "_cycles"}, 32'(cnt), 32'd64);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset then idle
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_init), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        start_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);   // held through scrub
        count_scrub("scrub0");
        @(posedge clk);
        #1 req_valid = 1'b0;
        get_rsp("lw_0", 32'h0, 1'b0);
        do_req("lw_4",  1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
        do_req("lw_fc", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b0);

        // byte-enable stores
        do_req("sw_0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344, 32'h0, 1'b0);
        do_req("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA, 32'h0, 1'b0);
        do_req("sh_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0);
        do_req("lw_0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hBEEFAA44, 1'b0);

        // load extension
        do_req("lb_0d",  1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0);
        do_req("lbu_0d", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 32'h000000AA, 1'b0);
        do_req("lh_0e",  1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu_0e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("lb_0c",  1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 32'h00000044, 1'b0);

        // errors
        do_req("sw_04",  1'b1, 2'b10, 1'b0, 32'h04,  32'hCAFEF00D, 32'h0, 1'b0);
        do_req("sw_06",  1'b1, 2'b10, 1'b0, 32'h06,  32'hDEADBEEF, 32'h0, 1'b1);
        do_req("lw_04",  1'b0, 2'b10, 1'b0, 32'h04,  32'h0, 32'hCAFEF00D, 1'b0);
        do_req("lh_03",  1'b0, 2'b01, 1'b0, 32'h03,  32'h0, 32'h0, 1'b1);
        do_req("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        do_req("rsv_sz", 1'b0, 2'b11, 1'b0, 32'h00,  32'h0, 32'h0, 1'b1);

        // store then load to the same word on consecutive accepts
        start_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h55667788);
        wait_accept("sw_10");
        start_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        get_rsp("sw_10", 32'h0, 1'b0);
        req_valid = 1'b0;
        get_rsp("lw_10_b2b", 32'h55667788, 1'b0);

        // backpressure
        rsp_ready = 1'b0;
        start_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        wait_accept("bp_lw");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_rdata", rsp_rdata, 32'hBEEFAA44);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        start_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0);
        wait_accept("bp_lbu");
        get_rsp("bp_lbu", 32'h000000AA, 1'b0);

        // mid-run reset
        do_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0);
        rsp_ready = 1'b0;
        start_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        wait_accept("lw_20_pend");
        @(negedge clk);
        check("pend_rdata", rsp_rdata, 32'h12345678);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        count_scrub("scrub1");
        @(posedge clk);
        #1;
        do_req("lw_20_after", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
